// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 16-channel one-hot ALU result mux: decodes an opcode to a
// select, waits a settle window, captures the mux output into acc, and repeats per count.
module alu_op_sequencer #(
    parameter int bus_size      = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [3:0]          cmd_count,
    input  logic                cmd_load,
    input  logic [bus_size-1:0] cmd_data,
    input  logic                abort,
    input  logic [bus_size-1:0] mux_b,
    output logic [15:0]         mux_s,
    output logic [bus_size-1:0] acc,
    output logic [3:0]          iter,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t              state, state_n;
    logic [3:0]          op_q, op_n;
    logic [3:0]          count_q, count_n;
    logic [3:0]          cnt, cnt_n;
    logic [3:0]          iter_q, iter_n;
    logic [bus_size-1:0] acc_q, acc_n;
    logic                aborted_q, aborted_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            count_q   <= '0;
            cnt       <= '0;
            iter_q    <= '0;
            acc_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            count_q   <= count_n;
            cnt       <= cnt_n;
            iter_q    <= iter_n;
            acc_q     <= acc_n;
            aborted_q <= aborted_n;
        end
    end

    always_comb begin
        state_n   = state;
        op_n      = op_q;
        count_n   = count_q;
        cnt_n     = cnt;
        iter_n    = iter_q;
        acc_n     = acc_q;
        aborted_n = aborted_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n      = cmd_op;
                    count_n   = cmd_count;
                    if (cmd_load) acc_n = cmd_data;
                    iter_n    = '0;
                    aborted_n = 1'b0;
                    cnt_n     = SETTLE_RELOAD;
                    state_n   = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = DONE;
                end else if (cnt == 4'd0) begin
                    state_n = CAPTURE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            CAPTURE: begin
                // Abort wins over the capture so acc keeps the last completed iteration.
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = DONE;
                end else begin
                    acc_n = mux_b;
                    if (iter_q == count_q) begin
                        state_n = DONE;
                    end else begin
                        iter_n  = iter_q + 4'd1;
                        cnt_n   = SETTLE_RELOAD;
                        state_n = SETTLE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Select is decoded from state so it can only ever be zero or a single hot bit.
    assign busy      = (state == SETTLE) || (state == CAPTURE);
    assign cmd_ready = (state == IDLE);
    assign done      = (state == DONE);
    assign mux_s     = busy ? (16'd1 << op_q) : 16'd0;
    assign acc       = acc_q;
    assign iter      = iter_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: single op, iterative loop, decode extremes,
// abort, busy rejection and asynchronous reset, plus a per-cycle one-hot check.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_count;
    logic        cmd_load;
    logic [15:0] cmd_data;
    logic        abort;
    logic [15:0] mux_b;
    logic [15:0] mux_s;
    logic [15:0] acc;
    logic [3:0]  iter;
    logic        busy;
    logic        done;
    logic        aborted;

    logic        model_en;
    logic [15:0] b_fixed;
    int          checks = 0;
    int          errors = 0;
    int          cyc, sel_cyc;
    logic [15:0] sel_seen;

    alu_op_sequencer #(.bus_size(16), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_load(cmd_load), .cmd_data(cmd_data),
        .abort(abort), .mux_b(mux_b), .mux_s(mux_s), .acc(acc), .iter(iter),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Mux output: either a fixed value or acc + 3 to emulate an add loop through the ALU.
    always_comb mux_b = model_en ? acc + 16'd3 : b_fixed;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert ($onehot0(mux_s)) else begin
                errors++;
                $error("FAIL onehot0: mux_s=%h", mux_s);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the first sample point after the accept edge (cycle 1).
    task automatic wait_done(output int c, output int sc, output logic [15:0] seen);
        c = 1; sc = 0; seen = '0;
        while (1) begin
            if (mux_s != 16'd0) begin sc++; seen |= mux_s; end
            if (done === 1'b1) break;
            if (c >= 200) begin
                check("done_timeout", 32'(c), 32'd0);
                break;
            end
            @(negedge clk);
            c++;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] cnt, input logic ld,
                         input logic [15:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_load = ld; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_count = 0; cmd_load = 0;
        cmd_data = 0; abort = 0; model_en = 0; b_fixed = 0;
        #12;
        check("rst_mux_s", 32'(mux_s), 32'h0);
        check("rst_acc", 32'(acc), 32'h0);
        check("rst_iter", 32'(iter), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_aborted", 32'(aborted), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op
        b_fixed = 16'h1234;
        issue(4'd5, 4'd0, 1'b0, 16'h0);
        check("single_sel_c1", 32'(mux_s), 32'h0020);
        check("single_busy_c1", 32'(busy), 32'h1);
        wait_done(cyc, sel_cyc, sel_seen);
        check("single_done_cyc", 32'(cyc), 32'd4);
        check("single_sel_cycles", 32'(sel_cyc), 32'd3);
        check("single_sel_seen", 32'(sel_seen), 32'h0020);
        check("single_acc", 32'(acc), 32'h1234);
        check("single_iter", 32'(iter), 32'h0);
        check("single_done_mux", 32'(mux_s), 32'h0);
        check("single_done_busy", 32'(busy), 32'h0);
        check("single_done_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        check("single_after_done", 32'(done), 32'h0);
        check("single_after_mux", 32'(mux_s), 32'h0);
        check("single_after_ready", 32'(cmd_ready), 32'h1);

        // Iterative add loop
        model_en = 1'b1;
        issue(4'd2, 4'd3, 1'b1, 16'h0010);
        check("loop_acc_load", 32'(acc), 32'h0010);
        wait_done(cyc, sel_cyc, sel_seen);
        check("loop_done_cyc", 32'(cyc), 32'd13);
        check("loop_sel_cycles", 32'(sel_cyc), 32'd12);
        check("loop_sel_seen", 32'(sel_seen), 32'h0004);
        check("loop_acc", 32'(acc), 32'h001C);
        check("loop_iter", 32'(iter), 32'h3);
        @(negedge clk);
        check("loop_acc_hold", 32'(acc), 32'h001C);
        check("loop_iter_hold", 32'(iter), 32'h3);

        // Decode extremes; op 15 also accepted with abort high in IDLE
        model_en = 1'b0;
        b_fixed  = 16'h00FF;
        issue(4'd0, 4'd0, 1'b0, 16'h0);
        wait_done(cyc, sel_cyc, sel_seen);
        check("op0_sel", 32'(sel_seen), 32'h0001);
        check("op0_acc", 32'(acc), 32'h00FF);
        @(negedge clk);
        b_fixed = 16'hFFFF;
        abort   = 1'b1;
        issue(4'd15, 4'd0, 1'b0, 16'h0);
        abort = 1'b0;
        check("op15_accept_abort", 32'(busy), 32'h1);
        wait_done(cyc, sel_cyc, sel_seen);
        check("op15_sel", 32'(sel_seen), 32'h8000);
        check("op15_done_cyc", 32'(cyc), 32'd4);
        check("op15_acc", 32'(acc), 32'hFFFF);
        check("op15_aborted", 32'(aborted), 32'h0);
        @(negedge clk);

        // Abort in 2nd SETTLE cycle of iteration 1
        model_en = 1'b1;
        issue(4'd7, 4'd5, 1'b1, 16'h0100);
        repeat (4) @(negedge clk);
        check("abort_pre_sel", 32'(mux_s), 32'h0080);
        check("abort_pre_iter", 32'(iter), 32'h1);
        check("abort_pre_acc", 32'(acc), 32'h0103);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", 32'(done), 32'h1);
        check("abort_flag", 32'(aborted), 32'h1);
        check("abort_acc", 32'(acc), 32'h0103);
        check("abort_mux", 32'(mux_s), 32'h0);
        check("abort_iter", 32'(iter), 32'h1);
        @(negedge clk);
        check("abort_flag_hold", 32'(aborted), 32'h1);
        check("abort_ready", 32'(cmd_ready), 32'h1);

        // Busy rejection: second command held on cmd_valid
        model_en = 1'b0;
        b_fixed  = 16'h0055;
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_count = 4'd0; cmd_load = 1'b0;
        @(negedge clk);
        cmd_op = 4'd9;
        wait_done(cyc, sel_cyc, sel_seen);
        check("rej_first_cyc", 32'(cyc), 32'd4);
        check("rej_first_sel", 32'(sel_seen), 32'h0008);
        check("rej_aborted_clr", 32'(aborted), 32'h0);
        @(negedge clk);
        check("rej_idle_ready", 32'(cmd_ready), 32'h1);
        check("rej_idle_mux", 32'(mux_s), 32'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rej_second_sel", 32'(mux_s), 32'h0200);
        wait_done(cyc, sel_cyc, sel_seen);
        check("rej_second_cyc", 32'(cyc), 32'd4);
        @(negedge clk);

        // Async reset mid-SETTLE of iteration 1
        b_fixed = 16'hBEEF;
        issue(4'd4, 4'd2, 1'b1, 16'hBEEF);
        repeat (3) @(negedge clk);
        check("ar_pre_acc", 32'(acc), 32'hBEEF);
        check("ar_pre_iter", 32'(iter), 32'h1);
        check("ar_pre_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_mux", 32'(mux_s), 32'h0);
        check("ar_acc", 32'(acc), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_iter", 32'(iter), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_ready", 32'(cmd_ready), 32'h1);
        check("ar_busy_after", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
